dt_estimator: RTL and testbench
===============================

DT_ESTIMATOR -- requirements
Module: dt_estimator

Interface
REQ-001 Parameter LAG, default 4, meaning sample distance used for the difference, legal range 1..8.
REQ-002 Parameter GAIN_SHL, default 0, meaning left-shift gain applied to the raw difference, legal range 0..3.
REQ-003 clk  input  1  system clock; all state SHALL be updated on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 t_in  input  8  signed Q7.0 temperature sample.
REQ-006 t_valid  input  1  one-cycle strobe; t_in SHALL be captured in any cycle where this input is high.
REQ-007 clr  input  1  synchronous flush of the history; takes effect in the cycle it is sampled high.
REQ-008 dt_out  output  8  signed Q7.0 saturated derivative; connects to fuzzifier_dT input x.
REQ-009 dt_valid  output  1  one-cycle pulse; marks a new dt_out.
REQ-010 primed  output  1  high once LAG+1 samples are held since the last reset or clr.

Function
REQ-011 History: circular buffer of LAG+1 entries with a write pointer. The pointer SHALL wrap from LAG to 0.
REQ-012 FSM states: FILL (count < LAG+1) and RUN.
  - Each accepted sample SHALL increment the fill counter while in FILL.
  - The FSM SHALL enter RUN on the sample that makes the count equal LAG+1.
REQ-013 In FILL, dt_valid SHALL stay 0 and dt_out SHALL hold its value.
REQ-014 In RUN, each accepted sample SHALL produce:
  - raw = t_in − T[n−LAG], computed 9-bit signed;
  - scaled = raw << GAIN_SHL, computed 12-bit signed;
  - dt_out = scaled saturated to [−128, 127].
REQ-015 Latency: dt_out and dt_valid SHALL be registered and appear exactly 1 cycle after the t_valid cycle.
  - dt_valid SHALL be high for exactly one cycle.
REQ-016 The sample that completes FILL SHALL itself produce the first dt_valid, one cycle later.
REQ-017 Back-to-back t_valid on consecutive cycles SHALL be accepted with no stall, one dt_valid per sample.
REQ-018 Saturation SHALL be symmetric-safe:
  - +255 → 127;
  - −255 → −128;
  - no wrap-around on any input pair.
REQ-019 clr has priority over t_valid in the same cycle. Effects:
  - the sample is dropped;
  - fill counter, write pointer and primed SHALL go to 0;
  - the FSM SHALL go to FILL;
  - dt_out SHALL be held;
  - no dt_valid SHALL be issued.
REQ-020 primed SHALL equal (state == RUN) and be registered.

Reset
REQ-021 On rst high, without waiting for a clock edge, the block SHALL set:
  - dt_out = 0 and dt_valid = 0;
  - primed = 0;
  - FSM = FILL, fill counter = 0, write pointer = 0;
  - history contents to 0.
REQ-022 A reset asserted mid-stream SHALL discard all history; the next LAG+1 samples SHALL re-fill the buffer.
REQ-023 No dt_valid SHALL be issued in the cycle reset is released.

Structure
REQ-024 Shared package fuzzy_pkg SHALL hold:
  - typedef q7_t (signed 8-bit);
  - constants Q7_MAX = 127 and Q7_MIN = −128;
  - the dt_state_e enum {FILL, RUN};
  - function sat_q7 (12-bit signed → q7_t).
REQ-025 One sub-module, dt_history_buf, SHALL implement the circular buffer. Its interface:
  - write enable and data in;
  - LAG-delayed read data out;
  - pointer wrap.
  The FSM, arithmetic and saturation SHALL remain in dt_estimator.

Verification
REQ-026 Ramp test, LAG=4, GAIN_SHL=0:
  - stimulus: t_in = 0,1,2,…,10 on consecutive cycles;
  - first dt_valid follows the 5th sample;
  - dt_out = 4 on every valid;
  - primed rises with the 5th sample.
REQ-027 Saturation test, LAG=1:
  - samples −128 then 127 → dt_out = 127;
  - samples 127 then −128 → dt_out = −128.
REQ-028 Gain test, LAG=1, GAIN_SHL=3:
  - samples 10 then 30 (raw 20, scaled 160) → dt_out = 127;
  - samples 30 then 25 → dt_out = −40.
REQ-029 clr test, LAG=4:
  - clr and t_valid asserted together after 6 samples → no dt_valid, primed = 0;
  - then 4 more samples → still no dt_valid;
  - 5th sample → dt_valid.
REQ-030 Async reset test:
  - assert rst between clock edges mid-stream → dt_out = 0 and primed = 0 immediately;
  - after release, behaviour matches REQ-026 from the start.
REQ-031 Gapped strobes test:
  - t_valid every 3rd cycle with random values;
  - dt_out compared per sample against a software model of REQ-014;
  - dt_out always within [−128, 127].

Source files
------------

// File: rtl/fuzzy_pkg.sv
// Shared fixed-point types, limits and saturation helper for the fuzzy front end.
// Q7.0 values are plain signed bytes; saturation clamps a 12-bit intermediate.
package fuzzy_pkg;

    typedef logic signed [7:0] q7_t;

    localparam q7_t Q7_MAX = 8'sh7f;
    localparam q7_t Q7_MIN = 8'sh80;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } dt_state_e;

    function automatic q7_t sat_q7(input logic signed [11:0] v);
        if (v > 12'sd127) begin
            return Q7_MAX;
        end else if (v < -12'sd128) begin
            return Q7_MIN;
        end else begin
            return v[7:0];
        end
    endfunction

endpackage

// File: rtl/dt_history_buf.sv
// Circular sample history of LAG+1 entries; rd_data is the sample LAG writes older than wr_data.
// Read is combinational, write takes effect on the clock edge; never stalls.
module dt_history_buf
    import fuzzy_pkg::*;
#(
    parameter int LAG = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        wr_en,
    input  logic signed [7:0] wr_data,
    output logic signed [7:0] rd_data
);

    localparam int PW = $clog2(LAG + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(LAG);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    q7_t           mem [LAG+1];

    // The slot just after the write pointer holds the oldest of the LAG+1 kept samples.
    assign rd_ptr  = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            for (int i = 0; i <= LAG; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            wr_ptr <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/dt_estimator.sv
// Temperature derivative: saturated (t[n] - t[n-LAG]) << GAIN_SHL, 1-cycle registered latency.
// No backpressure: every t_valid strobe is accepted; clr flushes history and drops that sample.
module dt_estimator
    import fuzzy_pkg::*;
#(
    parameter int LAG      = 4,
    parameter int GAIN_SHL = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic signed [7:0] t_in,
    input  logic              t_valid,
    input  logic              clr,
    output logic signed [7:0] dt_out,
    output logic              dt_valid,
    output logic              primed
);

    localparam int CW = $clog2(LAG + 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(LAG);

    dt_state_e         state;
    logic [CW-1:0]     fill_cnt;
    logic signed [7:0] old_sample;
    logic signed [8:0] raw;
    logic signed [11:0] raw_ext;
    logic signed [11:0] scaled;
    logic              accept;

    assign accept = t_valid & ~clr;

    dt_history_buf #(.LAG(LAG)) u_hist (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .wr_en   (accept),
        .wr_data (t_in),
        .rd_data (old_sample)
    );

    // 9 bits hold any byte difference; 12 bits hold it after a shift of up to 3.
    assign raw     = {t_in[7], t_in} - {old_sample[7], old_sample};
    assign raw_ext = {{3{raw[8]}}, raw};
    assign scaled  = raw_ext <<< GAIN_SHL;

    assign primed  = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FILL;
            fill_cnt <= '0;
            dt_out   <= '0;
            dt_valid <= 1'b0;
        end else begin
            dt_valid <= 1'b0;
            if (clr) begin
                state    <= FILL;
                fill_cnt <= '0;
            end else if (t_valid) begin
                if (state == FILL) begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (fill_cnt == CNT_LAST) begin
                        state <= RUN;
                    end
                end
                // The sample completing the fill already has its LAG-old partner.
                if (state == RUN || fill_cnt == CNT_LAST) begin
                    dt_out   <= sat_q7(scaled);
                    dt_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dt_estimator.sv
// Two derivative estimators (LAG=4/x1 and LAG=1/x8) on a shared stimulus, checked against a queue model.
module tb_dt_estimator;

    localparam int LAG_A = 4;
    localparam int G_A   = 0;
    localparam int LAG_B = 1;
    localparam int G_B   = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic signed [7:0] t_in;
    logic              t_valid;
    logic              clr;
    logic signed [7:0] dt_a, dt_b;
    logic              dv_a, dv_b, pr_a, pr_b;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    int qa[$];
    int qb[$];
    int exp_dt_a, exp_dt_b;
    bit exp_v_a, exp_v_b, exp_p_a, exp_p_b;

    always #5 clk = ~clk;

    dt_estimator #(.LAG(LAG_A), .GAIN_SHL(G_A)) u_a (
        .clk(clk), .rst(rst), .t_in(t_in), .t_valid(t_valid), .clr(clr),
        .dt_out(dt_a), .dt_valid(dv_a), .primed(pr_a)
    );

    dt_estimator #(.LAG(LAG_B), .GAIN_SHL(G_B)) u_b (
        .clk(clk), .rst(rst), .t_in(t_in), .t_valid(t_valid), .clr(clr),
        .dt_out(dt_b), .dt_valid(dv_b), .primed(pr_b)
    );

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int dt_model(input int cur, input int old, input int g);
        int s;
        s = (cur - old) * (1 << g);
        if (s > 127) return 127;
        if (s < -128) return -128;
        return s;
    endfunction

    function automatic void model_reset();
        qa.delete();
        qb.delete();
        exp_dt_a = 0; exp_dt_b = 0;
        exp_v_a  = 0; exp_v_b  = 0;
        exp_p_a  = 0; exp_p_b  = 0;
    endfunction

    function automatic void model_step(input bit v, input int x, input bit c);
        exp_v_a = 0;
        exp_v_b = 0;
        if (c) begin
            qa.delete();
            qb.delete();
            exp_p_a = 0;
            exp_p_b = 0;
        end else if (v) begin
            qa.push_back(x);
            if (qa.size() > LAG_A) begin
                exp_dt_a = dt_model(x, qa[qa.size() - 1 - LAG_A], G_A);
                exp_v_a  = 1;
                exp_p_a  = 1;
                void'(qa.pop_front());
            end
            qb.push_back(x);
            if (qb.size() > LAG_B) begin
                exp_dt_b = dt_model(x, qb[qb.size() - 1 - LAG_B], G_B);
                exp_v_b  = 1;
                exp_p_b  = 1;
                void'(qb.pop_front());
            end
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_valid",  int'(dv_a), int'(exp_v_a));
            chk("a_dt",     int'(dt_a), exp_dt_a);
            chk("a_primed", int'(pr_a), int'(exp_p_a));
            chk("b_valid",  int'(dv_b), int'(exp_v_b));
            chk("b_dt",     int'(dt_b), exp_dt_b);
            chk("b_primed", int'(pr_b), int'(exp_p_b));
        end
    end

    // Called at a negedge; returns at the following negedge after the compare point.
    task automatic step(input bit v, input int x, input bit c);
        t_valid = v;
        t_in    = 8'(x);
        clr     = c;
        @(posedge clk);
        model_step(v, x, c);
        @(negedge clk);
        t_valid = 1'b0;
        clr     = 1'b0;
    endtask

    task automatic ramp();
        for (int i = 0; i <= 10; i++) begin
            step(1'b1, i, 1'b0);
            if (i < 4) begin
                chk("ramp_a_novalid", int'(dv_a), 0);
                chk("ramp_a_primed0", int'(pr_a), 0);
            end else begin
                chk("ramp_a_valid",  int'(dv_a), 1);
                chk("ramp_a_dt",     int'(dt_a), 4);
                chk("ramp_a_primed", int'(pr_a), 1);
            end
            if (i >= 1) chk("ramp_b_dt", int'(dt_b), 8);
        end
    endtask

    function automatic int rnd_q7();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    initial begin
        rst     = 1'b1;
        t_valid = 1'b0;
        clr     = 1'b0;
        t_in    = '0;
        model_reset();
        #1;
        chk("reset_a_dt",     int'(dt_a), 0);
        chk("reset_a_valid",  int'(dv_a), 0);
        chk("reset_a_primed", int'(pr_a), 0);
        chk("reset_b_dt",     int'(dt_b), 0);
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;

        ramp();

        // LAG=1 with x8 gain: saturation at both extremes and an in-range negative result.
        step(1'b1, -128, 1'b0);
        step(1'b1,  127, 1'b0);
        chk("sat_pos", int'(dt_b), 127);
        step(1'b1, -128, 1'b0);
        chk("sat_neg", int'(dt_b), -128);
        step(1'b1, 10, 1'b0);
        step(1'b1, 30, 1'b0);
        chk("gain_sat", int'(dt_b), 127);
        step(1'b1, 25, 1'b0);
        chk("gain_neg40", int'(dt_b), -40);
        chk("gain_valid", int'(dv_b), 1);

        // clr together with t_valid after six samples.
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, rnd_q7(), 1'b0);
        step(1'b1, 55, 1'b1);
        chk("clr_novalid", int'(dv_a), 0);
        chk("clr_primed0", int'(pr_a), 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, rnd_q7(), 1'b0);
            chk("clr_refill_novalid", int'(dv_a), 0);
        end
        step(1'b1, rnd_q7(), 1'b0);
        chk("clr_refill_valid", int'(dv_a), 1);

        // Gapped strobes, one sample every third cycle.
        for (int k = 0; k < 60; k++) begin
            step(1'b1, rnd_q7(), 1'b0);
            step(1'b0, 0, 1'b0);
            step(1'b0, 0, 1'b0);
        end

        // Asynchronous reset between clock edges, then a fresh ramp.
        step(1'b1, 100, 1'b0);
        step(1'b1, -100, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("arst_a_dt",     int'(dt_a), 0);
        chk("arst_a_primed", int'(pr_a), 0);
        chk("arst_b_dt",     int'(dt_b), 0);
        chk("arst_b_primed", int'(pr_b), 0);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        ramp();

        // Random back-to-back traffic with occasional flushes.
        for (int k = 0; k < 300; k++) begin
            step(1'($urandom_range(0, 1)), rnd_q7(), ($urandom_range(0, 19) == 0));
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
